// File: rtl/reg_xfer_pkg.sv
// Shared encodings for the register-transfer controller: opcodes and FSM states.
package reg_xfer_pkg;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_SWAP = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER1 = 3'd1,
    S_XFER2 = 3'd2,
    S_XFER3 = 3'd3,
    S_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Gated index-to-one-hot decoder; bits above NUM_REGS-1 are never produced.
module onehot_dec #(
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_bit
    assign onehot[k] = en && (idx == IDX_W'(k));
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer controller: MOV / SWAP (via temp) / CLR over a shared bus,
// with Moore outputs and a busy/done/err handshake to the sequencer.
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [IDX_W-1:0]    ri,
  input  logic [IDX_W-1:0]    rj,
  output logic [NUM_REGS-1:0] reg_write,
  output logic [NUM_REGS-1:0] reg_read,
  output logic                tmp_write,
  output logic                tmp_read,
  output logic                zero_drive,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // One extra bit so NUM_REGS=2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] ri_q, rj_q;
  logic             err_q, err_d;
  logic             req_bad;

  logic             wr_en, rd_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  always_comb begin
    req_bad = (op == OP_RSVD) ||
              ({1'b0, ri} >= NREGS) ||
              ((op != OP_CLR) && ({1'b0, rj} >= NREGS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      op_q    <= OP_MOV;
      ri_q    <= '0;
      rj_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && start) begin
        op_q <= op;
        ri_q <= ri;
        rj_q <= rj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = S_XFER1;
          end
        end
      end
      S_XFER1: state_d = (op_q == OP_SWAP) ? S_XFER2 : S_FIN;
      S_XFER2: state_d = S_XFER3;
      S_XFER3: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Output decode depends only on state_q and the latched operands.
  always_comb begin
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_idx     = ri_q;
    rd_idx     = rj_q;
    tmp_write  = 1'b0;
    tmp_read   = 1'b0;
    zero_drive = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_XFER1: begin
        if (op_q == OP_SWAP) begin
          rd_en     = 1'b1;
          rd_idx    = ri_q;
          tmp_write = 1'b1;
        end else if (op_q == OP_CLR) begin
          zero_drive = 1'b1;
          wr_en      = 1'b1;
        end else begin
          rd_en = 1'b1;
          wr_en = 1'b1;
        end
      end
      S_XFER2: begin
        rd_en = 1'b1;
        wr_en = 1'b1;
      end
      S_XFER3: begin
        tmp_read = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = rj_q;
      end
      S_FIN: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  onehot_dec #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_wr_dec (
    .en     (wr_en),
    .idx    (wr_idx),
    .onehot (reg_write)
  );

  onehot_dec #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_rd_dec (
    .en     (rd_en),
    .idx    (rd_idx),
    .onehot (reg_read)
  );

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed vector bench for reg_xfer_ctrl at NUM_REGS=4 and NUM_REGS=8,
// with a bus/register model on the 4-register instance.
module tb_reg_xfer_ctrl;
  import reg_xfer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] ri = '0, rj = '0;

  logic [3:0] wr4, rd4;
  logic       tw4, tr4, zd4, busy4, done4, err4;
  logic [7:0] wr8, rd8;
  logic       tw8, tr8, zd8, busy8, done8, err8;

  reg_xfer_ctrl #(.NUM_REGS(4), .IDX_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .ri(ri), .rj(rj),
    .reg_write(wr4), .reg_read(rd4), .tmp_write(tw4), .tmp_read(tr4),
    .zero_drive(zd4), .busy(busy4), .done(done4), .err(err4)
  );

  reg_xfer_ctrl #(.NUM_REGS(8), .IDX_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .ri(ri), .rj(rj),
    .reg_write(wr8), .reg_read(rd8), .tmp_write(tw8), .tmp_read(tr8),
    .zero_drive(zd8), .busy(busy8), .done(done8), .err(err8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        d8;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  ri;
    logic [3:0]  rj;
    logic [21:0] exp;
  } vec_t;

  localparam logic [5:0] IDL = 6'b000000;
  localparam logic [5:0] B   = 6'b000100;
  localparam logic [5:0] DN  = 6'b000110;
  localparam logic [5:0] DE  = 6'b000111;
  localparam logic [5:0] TW  = 6'b100100;
  localparam logic [5:0] TR  = 6'b010100;
  localparam logic [5:0] ZD  = 6'b001100;

  int n_vec = 0;
  int n_bad = 0;
  int viol  = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic d8, logic st, logic [1:0] o, logic [3:0] i, logic [3:0] j,
                              logic [7:0] r, logic [7:0] w, logic [5:0] f);
    vec_t v;
    v.d8 = d8; v.start = st; v.op = o; v.ri = i; v.rj = j;
    v.exp = {r, w, f};
    return v;
  endfunction

  function automatic logic [21:0] obs4();
    return {4'b0, rd4, 4'b0, wr4, tw4, tr4, zd4, busy4, done4, err4};
  endfunction

  function automatic logic [21:0] obs8();
    return {rd8, wr8, tw8, tr8, zd8, busy8, done8, err8};
  endfunction

  task automatic chk(input string name, input logic [21:0] got, input logic [21:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Bus/register model driven by the 4-register instance's enables.
  logic [7:0] regs[4];
  logic [7:0] tmp_reg;
  logic [7:0] s_bus;
  logic [3:0] s_wr;
  logic       s_tw;

  always @(negedge clk) begin
    logic [7:0] b;
    b = 8'h00;
    if (tr4) b = tmp_reg;
    for (int k = 0; k < 4; k++) if (rd4[k]) b = regs[k];
    if (zd4) b = 8'h00;
    s_bus <= b;
    s_wr  <= wr4;
    s_tw  <= tw4;
    if ($countones(wr4) > 1 || $countones(rd4) > 1 ||
        (int'(|rd4) + int'(tr4) + int'(zd4)) > 1) viol++;
    if ($countones(wr8) > 1 || $countones(rd8) > 1 ||
        (int'(|rd8) + int'(tr8) + int'(zd8)) > 1) viol++;
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (s_tw) tmp_reg <= s_bus;
      for (int k = 0; k < 4; k++) if (s_wr[k]) regs[k] <= s_bus;
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) regs[k] = 8'hA0 + 8'(k);
    tmp_reg = 8'h00;
    s_bus = '0; s_wr = '0; s_tw = 1'b0;

    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_MOV, 2,1, 8'h02,8'h04,B));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_SWAP,0,3, 8'h01,8'h00,TW));
    vecs.push_back(mk(0,1,OP_SWAP,1,2, 8'h08,8'h01,B));
    vecs.push_back(mk(0,1,OP_MOV, 2,1, 8'h00,8'h08,TR));
    vecs.push_back(mk(0,1,OP_MOV, 2,1, 8'h00,8'h00,DN));
    vecs.push_back(mk(0,1,OP_MOV, 2,1, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_CLR, 3,7, 8'h00,8'h08,ZD));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_RSVD,0,0, 8'h00,8'h00,DE));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_MOV, 0,4, 8'h00,8'h00,DE));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_CLR, 4,0, 8'h00,8'h00,DE));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_MOV, 1,1, 8'h02,8'h02,B));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(0,1,OP_SWAP,2,2, 8'h04,8'h00,TW));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h04,8'h04,B));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h04,TR));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(0,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(1,1,OP_MOV, 7,5, 8'h20,8'h80,B));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));
    vecs.push_back(mk(1,1,OP_SWAP,7,5, 8'h80,8'h00,TW));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h20,8'h80,B));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h00,8'h20,TR));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h00,8'h00,DN));
    vecs.push_back(mk(1,0,OP_MOV, 0,0, 8'h00,8'h00,IDL));

    // Reset state, then the first cycle after release.
    #2;
    chk("rst4", obs4(), '0);
    chk("rst8", obs8(), '0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", obs4(), '0);

    foreach (vecs[n]) begin
      @(negedge clk);
      start = vecs[n].start; op = vecs[n].op; ri = vecs[n].ri; rj = vecs[n].rj;
      @(posedge clk); #1;
      if (vecs[n].d8) chk($sformatf("vec%0d_n8", n), obs8(), vecs[n].exp);
      else            chk($sformatf("vec%0d_n4", n), obs4(), vecs[n].exp);
    end

    @(negedge clk);
    start = 1'b0;
    chk("r0", {14'b0, regs[0]}, 22'h0000A3);
    chk("r1", {14'b0, regs[1]}, 22'h0000A1);
    chk("r2", {14'b0, regs[2]}, 22'h0000A1);
    chk("r3", {14'b0, regs[3]}, 22'h000000);

    // Reset asserted while in XFER2 of a SWAP.
    start = 1'b1; op = OP_SWAP; ri = 4'd0; rj = 4'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("mid_xfer2", obs4(), {8'h08, 8'h01, B});
    #2 reset = 1'b1;
    #1 chk("async_rst", obs4(), '0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("after_rst%0d", c), obs4(), '0);
    end

    chk("excl", 22'(viol), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Parametrised register-transfer controller for the simple CPU datapath; successor to the fixed 4-register move FSM.
- Drives one-hot read/write enables for NUM_REGS registers plus a temp register sharing a single bus.
- Supports MOV, SWAP (three transfers through the temp register) and CLR (write zero).
- Gives a busy/done/err handshake to the instruction sequencer.

Parameters:
- NUM_REGS, 4, number of general-purpose registers on the bus (2..16).
- IDX_W, 4, width of the ri/rj index fields; indices >= NUM_REGS are illegal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MOV (ri<-rj), 01 SWAP (ri<->rj), 10 CLR (ri<-0), 11 reserved
- ri  in  IDX_W  destination / first operand index
- rj  in  IDX_W  source / second operand index (ignored for CLR)
- reg_write  out  NUM_REGS  one-hot write enable; register latches bus at next clk edge
- reg_read  out  NUM_REGS  one-hot bus-drive enable
- tmp_write  out  1  temp register latches bus
- tmp_read  out  1  temp register drives bus
- zero_drive  out  1  bus driven with 0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the request was rejected

Behaviour:
- Reset is asynchronous and active-high, on clk. It forces the state to IDLE and clears the latched op/ri/rj. All outputs read 0 while reset is high and in the first cycle after release.
- States: IDLE, XFER1, XFER2, XFER3, FIN.
- Outputs are Moore: decoded from the registered state and latched operands only. No combinational path from any input to any output.
- IDLE:
  - On a clk edge with start=1, latch op, ri, rj.
  - If op=11, ri>=NUM_REGS, or (op!=CLR and rj>=NUM_REGS), go to FIN with the error flag set.
  - Otherwise go to XFER1.
- XFER1:
  - MOV: reg_read[rj]=1, reg_write[ri]=1; then FIN.
  - CLR: zero_drive=1, reg_write[ri]=1; then FIN.
  - SWAP: reg_read[ri]=1, tmp_write=1; then XFER2.
- XFER2 (SWAP only): reg_read[rj]=1, reg_write[ri]=1; then XFER3.
- XFER3 (SWAP only): tmp_read=1, reg_write[rj]=1; then FIN.
- FIN: done=1; err=error flag; all enables 0; then IDLE unconditionally; error flag cleared.
- Exactly one bus driver is active in any transfer cycle. At most one reg_write bit is set, at most one reg_read bit is set, and never more than one of reg_read / tmp_read / zero_drive.
- Latency, start edge to done high:
  - MOV and CLR: 2 cycles.
  - SWAP: 4 cycles.
  - Rejected request: 1 cycle.
- The next start is accepted on the edge where FIN returns to IDLE+1, i.e. the first cycle with busy=0.
- start while busy: ignored, not queued.
- Changes on ri/rj/op while busy have no effect.
- ri==rj:
  - MOV executes normally (self-copy).
  - SWAP executes all three transfers; register content is unchanged.
- Reset mid-operation: enables drop immediately (asynchronous); the operation is abandoned with no done pulse.
- Index decode: one-hot of the latched index, masked to NUM_REGS bits. An out-of-range index never reaches the decoder because it is rejected in IDLE.

Decomposition:
- Package reg_xfer_pkg holds:
  - op encodings: OP_MOV=2'b00, OP_SWAP=2'b01, OP_CLR=2'b10, OP_RSVD=2'b11.
  - the state encoding constants.
- One sub-module, onehot_dec, parametrised by IDX_W and NUM_REGS, with an enable input. Instantiated twice: write index and read index.
- FSM, operand latches and output decode live in reg_xfer_ctrl.

Test Plan:
- MOV, NUM_REGS=4, ri=2, rj=1, start for 1 cycle.
  - Cycle 1: reg_read=0010, reg_write=0100, busy=1.
  - Cycle 2: done=1, err=0, enables 0.
  - Cycle 3: busy=0.
- SWAP ri=0, rj=3.
  - Cycle 1: reg_read=0001 and tmp_write.
  - Cycle 2: reg_read=1000 and reg_write=0001.
  - Cycle 3: tmp_read and reg_write=1000.
  - Cycle 4: done=1.
  - With a bus/register model, R0 and R3 contents are exchanged.
- CLR ri=3, rj=7 (ignored).
  - Cycle 1: zero_drive=1, reg_write=1000.
  - Cycle 2: done=1, err=0.
- Rejections:
  - op=11: next cycle done=1, err=1, no enable ever set.
  - MOV with rj=4 (NUM_REGS=4): same result.
- Protocol and reset:
  - start held high during a SWAP, with ri/rj toggled: single operation, original indices used.
  - Reset asserted during XFER2: all outputs 0 asynchronously; no done pulse; IDLE after release.
- Re-run the first MOV and SWAP scenarios with NUM_REGS=8, ri=7, rj=5: bit 7 and bit 5 enables asserted in the corresponding cycles.
